i2c_init_sequencer: RTL and testbench

Script-driven controller that sits in front of i2c_master and sequences it to run a device initialisation script, for example display or sensor configuration at power-up. It fetches 16-bit entries from a synchronous ROM. Each entry is either a register write, a delay, or an end marker. Each register write becomes one full I2C transaction: START, device address with W, register byte, data byte, STOP. NACKs are reported and the script is aborted.

---
 rtl/i2c_pkg.sv | 45 ++++
 rtl/i2c_delay_timer.sv | 46 ++++
 rtl/i2c_init_sequencer.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_i2c_init_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C init-script sequencer: FSM state encoding,
// script entry tags and the rule that builds the address byte.
package i2c_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_FWAIT,
        S_DECODE,
        S_START,
        S_ADDR,
        S_REG,
        S_DATA,
        S_STOP,
        S_NEXT,
        S_DELAY,
        S_FINISH
    } state_t;

    typedef enum logic [1:0] {
        E_WRITE,
        E_DELAY,
        E_END
    } entry_kind_t;

    localparam logic [7:0] END_REG   = 8'hFF;
    localparam logic [7:0] END_DATA  = 8'hFF;
    localparam logic [7:0] DELAY_REG = 8'hFE;

    // Address byte for a write transfer: 7-bit target address, R/W bit low.
    function automatic logic [7:0] addr_byte(input logic [6:0] dev);
        return {dev, 1'b0};
    endfunction

    // Classify one 16-bit script word ({reg, data}).
    function automatic entry_kind_t decode_entry(input logic [15:0] word);
        if (word[15:8] == END_REG && word[7:0] == END_DATA)
            return E_END;
        else if (word[15:8] == DELAY_REG)
            return E_DELAY;
        else
            return E_WRITE;
    endfunction

endpackage

// File: rtl/i2c_delay_timer.sv
// Script delay timer: on load, arms a countdown of value*DELAY_UNIT clk and
// raises expired once that many cycles have been spent waiting. A value of 0
// reports expired straight away.
module i2c_delay_timer
    import i2c_pkg::*;
#(
    parameter int unsigned DELAY_UNIT = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] value,
    output logic       expired
);

    localparam int unsigned CW = $clog2(255 * DELAY_UNIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Load the full cycle count, otherwise count down and stop at zero.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        cnt_d = cnt_q;
        if (load)
            cnt_d = CW'(value) * CW'(DELAY_UNIT);
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    // Countdown register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // The waiting state sees the loaded count on its first cycle, so ending
    // at a count of one spends exactly value*DELAY_UNIT cycles waiting.
    assign expired = (cnt_q <= CW'(1));

endmodule

// File: rtl/i2c_init_sequencer.sv
// I2C initialisation-script sequencer. Fetches {reg,data} words from a
// synchronous ROM and turns each into a full write transaction on an
// i2c_master (START, address+W, reg, data, STOP), with delay and end entries.
// A NACK issues STOP, flags error/err_index and ends the script.
// Build option: define I2C_RETRY_EN to retry a NACKed entry up to MAX_RETRY
// times before giving up.
module i2c_init_sequencer
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR   = 7'h3C,
    parameter int unsigned AW         = 5,
    parameter int unsigned DELAY_UNIT = 100000,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          go,
    output logic [AW-1:0] rom_addr,
    input  logic [15:0]   rom_data,
    output logic          m_start,
    output logic          m_stop,
    output logic          m_write,
    output logic          m_read,
    output logic          m_ack_in,
    output logic [7:0]    m_data_in,
    input  logic          m_done,
    input  logic          m_busy,
    input  logic          m_ack_err,
    output logic          running,
    output logic          finished,
    output logic          error,
    output logic [AW-1:0] err_index
);

    state_t        state_q,     state_d;
    logic [AW-1:0] index_q,     index_d;
    logic [AW-1:0] rom_addr_q,  rom_addr_d;
    logic [AW-1:0] err_index_q, err_index_d;
    logic [7:0]    reg_q,       reg_d;
    logic [7:0]    dat_q,       dat_d;
    logic [7:0]    data_q,      data_d;
    logic          start_q,     start_d;
    logic          stop_q,      stop_d;
    logic          write_q,     write_d;
    logic          running_q,   running_d;
    logic          finished_q,  finished_d;
    logic          error_q,     error_d;
    logic          abort_q,     abort_d;

`ifdef I2C_RETRY_EN
    localparam int unsigned RW = $clog2(MAX_RETRY + 2);
    logic [RW-1:0] retry_q, retry_d;
    logic          redo_q,  redo_d;
`endif

    logic timer_load;
    logic timer_expired;
    logic nack;

    i2c_delay_timer #(
        .DELAY_UNIT (DELAY_UNIT)
    ) u_delay_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (timer_load),
        .value   (rom_data[7:0]),
        .expired (timer_expired)
    );

    // A byte came back NACKed while one of our three bytes was in flight.
    assign nack = m_done && m_ack_err &&
                  (state_q == S_ADDR || state_q == S_REG || state_q == S_DATA);

    // Next-state and next-output logic of the sequencer FSM.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        rom_addr_d  = rom_addr_q;
        err_index_d = err_index_q;
        reg_d       = reg_q;
        dat_d       = dat_q;
        data_d      = data_q;
        start_d     = start_q;
        stop_d      = stop_q;
        write_d     = write_q;
        running_d   = running_q;
        finished_d  = 1'b0;
        error_d     = error_q;
        abort_d     = abort_q;
        timer_load  = 1'b0;
`ifdef I2C_RETRY_EN
        retry_d     = retry_q;
        redo_d      = redo_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    index_d   = '0;
                    error_d   = 1'b0;
                    abort_d   = 1'b0;
                    running_d = 1'b1;
                    state_d   = S_FETCH;
                end
            end

            S_FETCH: begin
                rom_addr_d = index_q;
                state_d    = S_FWAIT;
            end

            S_FWAIT: state_d = S_DECODE;

            S_DECODE: begin
                reg_d = rom_data[15:8];
                dat_d = rom_data[7:0];
`ifdef I2C_RETRY_EN
                retry_d = '0;
                redo_d  = 1'b0;
`endif
                case (decode_entry(rom_data))
                    E_END: begin
                        finished_d = 1'b1;
                        running_d  = 1'b0;
                        state_d    = S_FINISH;
                    end
                    E_DELAY: begin
                        timer_load = 1'b1;
                        state_d    = S_DELAY;
                    end
                    default: begin
                        start_d = 1'b1;
                        write_d = 1'b1;
                        data_d  = addr_byte(DEV_ADDR);
                        state_d = S_START;
                    end
                endcase
            end

            // Dropping start as soon as the master is busy keeps it from
            // re-issuing START when the address byte completes.
            S_START: begin
                if (m_busy) begin
                    start_d = 1'b0;
                    write_d = 1'b0;
                    state_d = S_ADDR;
                end
            end

            S_ADDR: begin
                if (m_done && !m_ack_err) begin
                    data_d  = reg_q;
                    state_d = S_REG;
                end
            end

            S_REG: begin
                if (m_done && !m_ack_err) begin
                    data_d  = dat_q;
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                if (m_done && !m_ack_err) begin
                    stop_d  = 1'b1;
                    state_d = S_STOP;
                end
            end

            S_STOP: begin
                if (m_done) begin
                    stop_d = 1'b0;
                    if (abort_q) begin
                        finished_d = 1'b1;
                        running_d  = 1'b0;
                        state_d    = S_FINISH;
`ifdef I2C_RETRY_EN
                    end else if (redo_q) begin
                        redo_d  = 1'b0;
                        start_d = 1'b1;
                        write_d = 1'b1;
                        data_d  = addr_byte(DEV_ADDR);
                        state_d = S_START;
`endif
                    end else begin
                        state_d = S_NEXT;
                    end
                end
            end

            S_NEXT: begin
                if (index_q == '1) begin
                    finished_d = 1'b1;
                    running_d  = 1'b0;
                    state_d    = S_FINISH;
                end else begin
                    index_d = index_q + 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_DELAY: begin
                if (timer_expired)
                    state_d = S_NEXT;
            end

            S_FINISH: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase

        // NACK path overrides the per-state ACK handling above.
        if (nack) begin
            stop_d  = 1'b1;
            state_d = S_STOP;
`ifdef I2C_RETRY_EN
            if (retry_q < RW'(MAX_RETRY)) begin
                retry_d = retry_q + 1'b1;
                redo_d  = 1'b1;
            end else begin
                abort_d     = 1'b1;
                error_d     = 1'b1;
                err_index_d = index_q;
            end
`else
            abort_d     = 1'b1;
            error_d     = 1'b1;
            err_index_d = index_q;
`endif
        end
    end

    // State and registered outputs; reset aborts mid-transaction silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            rom_addr_q  <= '0;
            err_index_q <= '0;
            reg_q       <= '0;
            dat_q       <= '0;
            data_q      <= '0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            write_q     <= 1'b0;
            running_q   <= 1'b0;
            finished_q  <= 1'b0;
            error_q     <= 1'b0;
            abort_q     <= 1'b0;
`ifdef I2C_RETRY_EN
            retry_q     <= '0;
            redo_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            rom_addr_q  <= rom_addr_d;
            err_index_q <= err_index_d;
            reg_q       <= reg_d;
            dat_q       <= dat_d;
            data_q      <= data_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            write_q     <= write_d;
            running_q   <= running_d;
            finished_q  <= finished_d;
            error_q     <= error_d;
            abort_q     <= abort_d;
`ifdef I2C_RETRY_EN
            retry_q     <= retry_d;
            redo_q      <= redo_d;
`endif
        end
    end

    assign rom_addr  = rom_addr_q;
    assign m_start   = start_q;
    assign m_stop    = stop_q;
    assign m_write   = write_q;
    assign m_read    = 1'b0;
    assign m_ack_in  = 1'b1;
    assign m_data_in = data_q;
    assign running   = running_q;
    assign finished  = finished_q;
    assign error     = error_q;
    assign err_index = err_index_q;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Bench for i2c_init_sequencer: a synchronous ROM, a cycle-level i2c_master
// stand-in that logs every byte and can NACK chosen bytes, and directed
// scripts with hand-computed expected bytes, counts and latencies.
module tb_i2c_init_sequencer;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          go = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data;
    logic          m_start, m_stop, m_write, m_read, m_ack_in;
    logic [7:0]    m_data_in;
    logic          m_done, m_busy, m_ack_err;
    logic          running, finished, error;
    logic [AW-1:0] err_index;

    logic [15:0] rom [4];
    bit          nack_mask [256];
    int          blog [$];
    int          n_starts = 0;
    int          n_stops = 0;
    int          fin_cnt = 0;
    int          cyc = 0;
    int          last_start_cyc = 0;
    int          go_c0 = 0;
    int          n_pass = 0;
    int          n_total = 0;

    i2c_init_sequencer #(
        .DEV_ADDR   (7'h3C),
        .AW         (AW),
        .DELAY_UNIT (10),
        .MAX_RETRY  (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .go        (go),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .m_start   (m_start),
        .m_stop    (m_stop),
        .m_write   (m_write),
        .m_read    (m_read),
        .m_ack_in  (m_ack_in),
        .m_data_in (m_data_in),
        .m_done    (m_done),
        .m_busy    (m_busy),
        .m_ack_err (m_ack_err),
        .running   (running),
        .finished  (finished),
        .error     (error),
        .err_index (err_index)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rom_data <= rom[rom_addr];
    always @(posedge clk) if (finished) fin_cnt <= fin_cnt + 1;

    // Master stand-in: START latches the address byte, each byte takes a few
    // clk then pulses done; two clk later it either STOPs or sends the next
    // byte from m_data_in.
    typedef enum {M_IDLE, M_BYTE, M_GAP, M_STOP, M_DONE} mstate_t;
    mstate_t ms;
    int      mcnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ms        <= M_IDLE;
            mcnt      <= 0;
            m_busy    <= 1'b0;
            m_done    <= 1'b0;
            m_ack_err <= 1'b0;
        end else begin
            m_done    <= 1'b0;
            m_ack_err <= 1'b0;
            case (ms)
                M_IDLE: if (m_start) begin
                    m_busy         <= 1'b1;
                    blog.push_back(int'(m_data_in));
                    n_starts       <= n_starts + 1;
                    last_start_cyc <= cyc;
                    mcnt           <= 3;
                    ms             <= M_BYTE;
                end
                M_BYTE: if (mcnt == 0) begin
                    m_done    <= 1'b1;
                    m_ack_err <= nack_mask[blog.size() - 1];
                    mcnt      <= 1;
                    ms        <= M_GAP;
                end else mcnt <= mcnt - 1;
                M_GAP: if (mcnt == 0) begin
                    mcnt <= 3;
                    if (m_stop) ms <= M_STOP;
                    else begin
                        blog.push_back(int'(m_data_in));
                        ms <= M_BYTE;
                    end
                end else mcnt <= mcnt - 1;
                M_STOP: if (mcnt == 0) begin
                    m_done  <= 1'b1;
                    m_busy  <= 1'b0;
                    n_stops <= n_stops + 1;
                    ms      <= M_DONE;
                end else mcnt <= mcnt - 1;
                default: ms <= M_IDLE;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic pulse_go();
        @(posedge clk); #1;
        go = 1'b1;
        go_c0 = cyc;
        @(posedge clk); #1;
        go = 1'b0;
    endtask

    task automatic wait_finished(input string tag, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            if (finished) seen = 1;
        end
        if (!seen) check({tag, "_timeout"}, 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_bytes(input string tag, input int n, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            if (blog.size() >= n) seen = 1;
        end
        if (!seen) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic load_rom(input logic [15:0] a, b, c, d);
        rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
    endtask

    int base, s0, p0, f0;

    task automatic mark();
        base = blog.size(); s0 = n_starts; p0 = n_stops; f0 = fin_cnt;
    endtask

    initial begin
        load_rom(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        check("rst_rom_addr", rom_addr, 0);
        check("rst_m_start", m_start, 0);
        check("rst_m_stop", m_stop, 0);
        check("rst_m_write", m_write, 0);
        check("rst_m_read", m_read, 0);
        check("rst_m_data_in", m_data_in, 0);
        check("rst_running", running, 0);
        check("rst_finished", finished, 0);
        check("rst_error", error, 0);
        check("rst_err_index", err_index, 0);
        check("m_ack_in_tied", m_ack_in, 1);
        reset = 1'b0;

        // 1: single write then END.
        load_rom(16'h0112, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        mark();
        pulse_go();
        check("t1_running", running, 1);
        wait_finished("t1", 300);
        check("t1_nbytes", blog.size() - base, 3);
        check("t1_b0", blog[base], 8'h78);
        check("t1_b1", blog[base + 1], 8'h01);
        check("t1_b2", blog[base + 2], 8'h12);
        check("t1_stops", n_stops - p0, 1);
        check("t1_fin", fin_cnt - f0, 1);
        check("t1_error", error, 0);
        check("t1_running_end", running, 0);
        check("t1_start_lat", last_start_cyc - go_c0, 4);

        // 2: delay of 3 units (30 clk) before the write.
        load_rom(16'hFE03, 16'h2055, 16'hFFFF, 16'hFFFF);
        mark();
        pulse_go();
        wait_finished("t2", 400);
        check("t2_nbytes", blog.size() - base, 3);
        check("t2_b1", blog[base + 1], 8'h20);
        check("t2_b2", blog[base + 2], 8'h55);
        check("t2_start_lat", last_start_cyc - go_c0, 38);
        check("t2_starts", n_starts - s0, 1);

`ifndef I2C_RETRY_EN
        // 3: NACK on the reg byte of entry 1 aborts the script.
        load_rom(16'h0112, 16'h0234, 16'h0356, 16'hFFFF);
        mark();
        nack_mask[base + 4] = 1;
        pulse_go();
        wait_finished("t3", 400);
        check("t3_nbytes", blog.size() - base, 5);
        check("t3_b4", blog[base + 4], 8'h02);
        check("t3_stops", n_stops - p0, 2);
        check("t3_error", error, 1);
        check("t3_err_index", err_index, 1);
        check("t3_fin", fin_cnt - f0, 1);
`else
        // 4a: two NACKs on the address byte, then success.
        load_rom(16'h0112, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        mark();
        nack_mask[base] = 1;
        nack_mask[base + 1] = 1;
        pulse_go();
        wait_finished("t4a", 600);
        check("t4a_starts", n_starts - s0, 3);
        check("t4a_nbytes", blog.size() - base, 5);
        check("t4a_b4", blog[base + 4], 8'h12);
        check("t4a_error", error, 0);
        // 4b: four NACKs exhaust the retries.
        mark();
        for (int i = 0; i < 4; i++) nack_mask[base + i] = 1;
        pulse_go();
        wait_finished("t4b", 800);
        check("t4b_starts", n_starts - s0, 4);
        check("t4b_stops", n_stops - p0, 4);
        check("t4b_error", error, 1);
        check("t4b_err_index", err_index, 0);
`endif

        // 5a: go while running is ignored; error from a prior abort clears.
        load_rom(16'h0112, 16'h0234, 16'hFFFF, 16'hFFFF);
        mark();
        pulse_go();
        check("t5a_err_clr", error, 0);
        wait_bytes("t5a", base + 1, 100);
        pulse_go();
        wait_finished("t5a", 600);
        check("t5a_nbytes", blog.size() - base, 6);
        check("t5a_starts", n_starts - s0, 2);
        check("t5a_fin", fin_cnt - f0, 1);

        // 5b: reset during the data byte, then restart from entry 0.
        mark();
        pulse_go();
        wait_bytes("t5b", base + 3, 100);
        reset = 1'b1;
        #1;
        check("t5b_m_start", m_start, 0);
        check("t5b_m_stop", m_stop, 0);
        check("t5b_m_data_in", m_data_in, 0);
        check("t5b_running", running, 0);
        check("t5b_rom_addr", rom_addr, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        mark();
        pulse_go();
        wait_finished("t5b", 600);
        check("t5b_nbytes", blog.size() - base, 6);
        check("t5b_restart_reg", blog[base + 1], 8'h01);
        check("t5b_stops", n_stops - p0, 2);

        // 6: full ROM with no END runs all 4 entries then finishes.
        load_rom(16'h0111, 16'h0222, 16'h0333, 16'h0444);
        mark();
        pulse_go();
        wait_finished("t6", 1000);
        check("t6_starts", n_starts - s0, 4);
        check("t6_nbytes", blog.size() - base, 12);
        check("t6_last_reg", blog[base + 10], 8'h04);
        check("t6_last_dat", blog[base + 11], 8'h44);
        check("t6_fin", fin_cnt - f0, 1);
        check("t6_error", error, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
